// File: rtl/msk_hpc3_pkg.sv
// Shared helpers for the masked HPC3 AND bus: randomness sizing,
// pair-to-random-bit mapping and flat bus index helpers.
package msk_hpc3_pkg;

    // Random bits needed per lane for a d-share HPC3 AND gadget.
    function automatic int calc_r(input int nd);
        return nd * (nd - 1);
    endfunction

    // Index of the random bit shared by the unordered share pair (i, j)
    // inside the r0 / r1 halves of a lane's randomness.
    function automatic int pair_idx(input int i, input int j, input int nd);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * nd - (lo * (lo + 1)) / 2 + (hi - 1 - lo);
    endfunction

    // Dense slot for ordered pair (i, j), j != i, in a d*(d-1) register.
    function automatic int slot_idx(input int i, input int j, input int nd);
        return i * (nd - 1) + ((j < i) ? j : j - 1);
    endfunction

    // Flat bus position of share s of lane k.
    function automatic int share_idx(input int lane, input int share, input int nd);
        return lane * nd + share;
    endfunction

endpackage

// File: rtl/msk_and_hpc3_lane.sv
// One lane of the HPC3 masked AND: d input shares per operand, stage
// registers (u, w, previous-a) loaded on 'load', registered-only output.
module msk_and_hpc3_lane
    import msk_hpc3_pkg::*;
#(
    parameter int d = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [d-1:0]           a,
    input  logic [d-1:0]           b,
    input  logic [calc_r(d)-1:0]   rnd,
    output logic [d-1:0]           z
);

    localparam int R = calc_r(d);
    localparam int H = R / 2;
    localparam int P = d * (d - 1);

    logic [P-1:0] u_d, u_q;
    logic [P-1:0] w_d, w_q;
    logic [d-1:0] ap_d, ap_q;

    // Next stage contents: hold unless a new operand is accepted.
    always_comb begin
        u_d  = u_q;
        w_d  = w_q;
        ap_d = ap_q;
        if (load) begin
            ap_d = a;
            for (int i = 0; i < d; i++) begin
                for (int j = 0; j < d; j++) begin
                    if (j != i) begin
                        // The first partner of share i also folds in the a_i*b_i term.
                        if (j == ((i == 0) ? 1 : 0))
                            u_d[slot_idx(i, j, d)] = (a[i] & (rnd[pair_idx(i, j, d)] ^ b[i]))
                                                     ^ rnd[H + pair_idx(i, j, d)];
                        else
                            u_d[slot_idx(i, j, d)] = (a[i] & rnd[pair_idx(i, j, d)])
                                                     ^ rnd[H + pair_idx(i, j, d)];
                        w_d[slot_idx(i, j, d)] = b[j] ^ rnd[pair_idx(i, j, d)];
                    end
                end
            end
        end
    end

    // Stage registers; cleared on reset so the output sharing reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_q  <= '0;
            w_q  <= '0;
            ap_q <= '0;
        end else begin
            u_q  <= u_d;
            w_q  <= w_d;
            ap_q <= ap_d;
        end
    end

    // Output shares computed from registered values only.
    always_comb begin
        z = '0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                if (j != i)
                    z[i] = z[i] ^ u_q[slot_idx(i, j, d)] ^ (ap_q[i] & w_q[slot_idx(i, j, d)]);
            end
        end
    end

endmodule

// File: rtl/msk_and_hpc3_bus.sv
// W-lane masked AND bus built from HPC3 lanes with valid/ready handshakes
// on operands, randomness and result. Define MSKAND_HPC3_OUTREG_EN to add
// a second registered output stage (latency 2, output straight from flops).
module msk_and_hpc3_bus
    import msk_hpc3_pkg::*;
#(
    parameter int d = 2,
    parameter int W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [d*W-1:0]           ina,
    input  logic [d*W-1:0]           inb,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W*d*(d-1)-1:0]     rnd,
    input  logic                     rnd_valid,
    output logic                     rnd_ready,
    output logic [d*W-1:0]           out,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int R = calc_r(d);

    logic             s_valid_d, s_valid_q;
    logic             s_adv;
    logic             s_free;
    logic             accept;
    logic [d*W-1:0]   z;

    for (genvar k = 0; k < W; k++) begin : g_lane
        msk_and_hpc3_lane #(.d(d)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (accept),
            .a     (ina[share_idx(k, 0, d) +: d]),
            .b     (inb[share_idx(k, 0, d) +: d]),
            .rnd   (rnd[k*R +: R]),
            .z     (z[share_idx(k, 0, d) +: d])
        );
    end

    // Operands and randomness are only taken together, never partially.
    assign s_free    = !s_valid_q || s_adv;
    assign accept    = in_valid && rnd_valid && s_free;
    assign in_ready  = rnd_valid && s_free;
    assign rnd_ready = in_valid && s_free;

    // Stage valid: set on accept, cleared when its contents move on.
    always_comb begin
        s_valid_d = s_valid_q;
        if (accept)
            s_valid_d = 1'b1;
        else if (s_valid_q && s_adv)
            s_valid_d = 1'b0;
    end

    // Stage valid register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s_valid_q <= 1'b0;
        else
            s_valid_q <= s_valid_d;
    end

`ifdef MSKAND_HPC3_OUTREG_EN
    logic             o_valid_d, o_valid_q;
    logic [d*W-1:0]   o_d, o_q;

    assign s_adv = !o_valid_q || out_ready;

    // Output stage: capture the lane result when it advances, else drain.
    always_comb begin
        o_valid_d = o_valid_q;
        o_d       = o_q;
        if (s_valid_q && s_adv) begin
            o_valid_d = 1'b1;
            o_d       = z;
        end else if (out_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_q       <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_q       <= o_d;
        end
    end

    assign out       = o_q;
    assign out_valid = o_valid_q;
`else
    assign s_adv     = out_ready;
    assign out       = z;
    assign out_valid = s_valid_q;
`endif

endmodule

// File: tb/tb_msk_and_hpc3_bus.sv
// Randomized self-checking bench for msk_and_hpc3_bus (d=3, W=8) against an
// elastic-pipeline scoreboard of unmasked a&b values.
module tb_msk_and_hpc3_bus;

    localparam int D  = 3;
    localparam int W  = 8;
    localparam int R  = D * (D - 1);
    localparam int RW = W * R;
    localparam int N  = D * W;
`ifdef MSKAND_HPC3_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  ina, inb, out;
    logic [RW-1:0] rnd;
    logic          in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready;

    msk_and_hpc3_bus #(.d(D), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ina       (ina),
        .inb       (inb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int res_cnt = 0;

    logic         mv[LAT];
    logic [W-1:0] mval[LAT];
    logic [W-1:0] a_cur, b_cur;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] unmask(input logic [N-1:0] s);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < W; k++)
            for (int i = 0; i < D; i++)
                v[k] = v[k] ^ s[k*D+i];
        return v;
    endfunction

    function automatic logic [N-1:0] mask(input logic [W-1:0] v);
        logic [N-1:0] s;
        logic         x;
        s = '0;
        for (int k = 0; k < W; k++) begin
            x = v[k];
            for (int i = 0; i < D - 1; i++) begin
                s[k*D+i] = 1'($urandom_range(0, 1));
                x = x ^ s[k*D+i];
            end
            s[k*D+D-1] = x;
        end
        return s;
    endfunction

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        a_cur = a;
        b_cur = b;
        ina   = mask(a);
        inb   = mask(b);
        for (int i = 0; i < RW; i++)
            rnd[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic model_clear();
        for (int k = 0; k < LAT; k++) begin
            mv[k]   = 1'b0;
            mval[k] = '0;
        end
    endtask

    function automatic logic model_busy();
        logic b;
        b = 1'b0;
        for (int k = 0; k < LAT; k++)
            b = b | mv[k];
        return b;
    endfunction

    // One clock: compare DUT against the model, then advance the model.
    task automatic tick();
        logic free[LAT];
        logic acc;
        #1;
        chk("out_valid", out_valid, mv[LAT-1]);
        if (mv[LAT-1])
            chk("out_value", unmask(out), mval[LAT-1]);
        free[LAT-1] = !mv[LAT-1] || out_ready;
        for (int k = LAT - 2; k >= 0; k--)
            free[k] = !mv[k] || free[k+1];
        chk("in_ready", in_ready, rnd_valid && free[0]);
        chk("rnd_ready", rnd_ready, in_valid && free[0]);
        acc = in_valid && rnd_valid && free[0];
        if (mv[LAT-1] && out_ready)
            res_cnt++;
        if (acc)
            acc_cnt++;
        @(posedge clk);
        for (int k = LAT - 1; k >= 1; k--)
            if (free[k]) begin
                mv[k]   = mv[k-1];
                mval[k] = mval[k-1];
            end
        if (free[0]) begin
            mv[0]   = acc;
            mval[0] = a_cur & b_cur;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] held;
        int a0, r0, cyc;
        in_valid = 0; rnd_valid = 0; out_ready = 0;
        ina = '0; inb = '0; rnd = '0; a_cur = '0; b_cur = '0;
        model_clear();

        // Reset state.
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed AND: 0xBB & 0x66 = 0x22.
        set_ops(8'hBB, 8'h66);
        in_valid = 1; rnd_valid = 1; out_ready = 1;
        tick();
        in_valid = 0; rnd_valid = 0;
        repeat (LAT - 1) tick();
        #1;
        chk("dir_valid", out_valid, 1);
        chk("dir_and", unmask(out), 8'h22);
        chk("model_pin", mval[LAT-1], 8'h22);

        // Stall with result held; inputs keep changing underneath.
        out_ready = 0; in_valid = 1; rnd_valid = 1;
        held = out;
        for (int s = 0; s < 5; s++) begin
            set_ops(W'($urandom), W'($urandom));
            #1;
            chk("stall_hold", out, held);
            if (s >= 1) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_rnd_ready", rnd_ready, 0);
            end
            tick();
        end
        out_ready = 1;
        set_ops(8'hF0, 8'h3C);
        tick();
        in_valid = 0; rnd_valid = 0;
        repeat (LAT + 2) tick();
        chk("stall_drained", model_busy(), 0);

        // rnd_valid toggling: exactly two accepts.
        a0 = acc_cnt; r0 = res_cnt;
        in_valid = 1;
        for (int t = 0; t < 4; t++) begin
            rnd_valid = (t % 2 == 0);
            set_ops(W'($urandom), W'($urandom));
            tick();
        end
        in_valid = 0; rnd_valid = 0;
        repeat (LAT + 2) tick();
        chk("toggle_accepts", acc_cnt - a0, 2);
        chk("toggle_results", res_cnt - r0, 2);

        // Asynchronous reset while a result is presented.
        set_ops(8'hAA, 8'hFF);
        in_valid = 1; rnd_valid = 1; out_ready = 0;
        tick();
        in_valid = 0; rnd_valid = 0;
        repeat (LAT - 1) tick();
        #1;
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_out", out, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1;
        set_ops(8'h5A, 8'hFF);
        in_valid = 1; rnd_valid = 1;
        tick();
        in_valid = 0; rnd_valid = 0;
        repeat (LAT - 1) tick();
        #1;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_and", unmask(out), 8'h5A);
        repeat (2) tick();

        // Random back-to-back traffic with random backpressure.
        a0 = acc_cnt; r0 = res_cnt; cyc = 0;
        while (((acc_cnt - a0) < 1000 || model_busy()) && cyc < 20000) begin
            in_valid  = ((acc_cnt - a0) < 1000) && ($urandom_range(0, 9) != 0);
            rnd_valid = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_ops(W'($urandom), W'($urandom));
            tick();
            cyc++;
        end
        chk("rand_in_budget", cyc < 20000, 1);
        chk("rand_accepts", acc_cnt - a0, 1000);
        chk("rand_results", res_cnt - r0, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
